// File: rtl/datapath_if.sv
// Control-unit to datapath strobe bundle: memory data, one-hot bus drive,
// register load enables and ALU selects, plus the observed bus value.
interface datapath_if;
    logic [31:0] MDatain;
    logic        Read;

    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        R2out;
    logic        R3out;
    logic        R7out;
    logic        LOout;
    logic        HIout;
    logic        InPortout;
    logic        Cout;

    logic        PCin;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        Yin;
    logic        Zin;
    logic        R6in;
    logic        R7in;

    logic        IncPC;
    logic        AND;
    logic        OR;
    logic        NEG;
    logic        NOT;

    logic [31:0] BusMuxOut;

    modport master (
        output MDatain, Read,
        output PCout, Zlowout, Zhighout, MDRout, R2out, R3out, R7out,
        output LOout, HIout, InPortout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, R6in, R7in,
        output IncPC, AND, OR, NEG, NOT,
        input  BusMuxOut
    );

    modport slave (
        input  MDatain, Read,
        input  PCout, Zlowout, Zhighout, MDRout, R2out, R3out, R7out,
        input  LOout, HIout, InPortout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, R6in, R7in,
        input  IncPC, AND, OR, NEG, NOT,
        output BusMuxOut
    );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file subset, PC/IR/MAR/MDR/Y/Z/HI/LO
// sharing one priority-muxed bus, with a small logic/increment ALU into Z.
module datapath (
    input  logic      clk,
    input  logic      clr,
    datapath_if.slave dp
);

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] in_port;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r6;
    logic [31:0] r7;
    logic [63:0] z;

    logic [31:0] bus;
    logic [31:0] c_sign;
    logic [31:0] alu_low;
    logic [31:0] mdr_next;

    // MAR and the opcode bits of IR are consumed by logic outside this core.
    logic unused_bits;
    assign unused_bits = ^{mar, ir[31:19]};

    always_comb begin
        c_sign = {{13{ir[18]}}, ir[18:0]};
    end

    always_comb begin
        bus = 32'd0;
        if (dp.PCout)
            bus = pc;
        else if (dp.Zlowout)
            bus = z[31:0];
        else if (dp.Zhighout)
            bus = z[63:32];
        else if (dp.MDRout)
            bus = mdr;
        else if (dp.R2out)
            bus = r2;
        else if (dp.R3out)
            bus = r3;
        else if (dp.R7out)
            bus = r7;
        else if (dp.LOout)
            bus = lo;
        else if (dp.HIout)
            bus = hi;
        else if (dp.InPortout)
            bus = in_port;
        else if (dp.Cout)
            bus = c_sign;
    end

    assign dp.BusMuxOut = bus;

    // Operand A is always Y and operand B is always the bus; the high half of Z is never produced.
    always_comb begin
        alu_low = 32'd0;
        if (dp.IncPC)
            alu_low = bus + 32'd1;
        else if (dp.AND)
            alu_low = y & bus;
        else if (dp.OR)
            alu_low = y | bus;
        else if (dp.NEG)
            alu_low = (~bus) + 32'd1;
        else if (dp.NOT)
            alu_low = ~bus;
    end

    always_comb begin
        mdr_next = dp.Read ? dp.MDatain : bus;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc  <= 32'd0;
            ir  <= 32'd0;
            mar <= 32'd0;
            mdr <= 32'd0;
            y   <= 32'd0;
            r6  <= 32'd0;
            r7  <= 32'd0;
            z   <= 64'd0;
        end else begin
            if (dp.PCin)
                pc <= bus;
            if (dp.IRin)
                ir <= bus;
            if (dp.MARin)
                mar <= bus;
            if (dp.MDRin)
                mdr <= mdr_next;
            if (dp.Yin)
                y <= bus;
            if (dp.R6in)
                r6 <= bus;
            if (dp.R7in)
                r7 <= bus;
            if (dp.Zin)
                z <= {32'd0, alu_low};
        end
    end

    // These sources have no load path yet; they hold their reset value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            in_port <= 32'd0;
            r2      <= 32'd0;
            r3      <= 32'd0;
        end else begin
            hi      <= hi;
            lo      <= lo;
            in_port <= in_port;
            r2      <= r2;
            r3      <= r3;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a microprogram table of strobe words with
// hand-computed bus/register expectations, plus reset and clr-release sequences.
module tb_datapath;

    localparam int S_PCOUT    = 0;
    localparam int S_ZLOWOUT  = 1;
    localparam int S_ZHIGHOUT = 2;
    localparam int S_MDROUT   = 3;
    localparam int S_R2OUT    = 4;
    localparam int S_R3OUT    = 5;
    localparam int S_R7OUT    = 6;
    localparam int S_LOOUT    = 7;
    localparam int S_HIOUT    = 8;
    localparam int S_INOUT    = 9;
    localparam int S_COUT     = 10;
    localparam int S_PCIN     = 11;
    localparam int S_IRIN     = 12;
    localparam int S_MARIN    = 13;
    localparam int S_MDRIN    = 14;
    localparam int S_YIN      = 15;
    localparam int S_ZIN      = 16;
    localparam int S_R6IN     = 17;
    localparam int S_R7IN     = 18;
    localparam int S_INCPC    = 19;
    localparam int S_AND      = 20;
    localparam int S_OR       = 21;
    localparam int S_NEG      = 22;
    localparam int S_NOT      = 23;
    localparam int S_READ     = 24;

    localparam int SEL_BUS = 0;
    localparam int SEL_R6  = 1;
    localparam int SEL_MAR = 2;
    localparam int SEL_IR  = 3;

    typedef struct {
        logic [31:0] ctl;
        logic [31:0] mdata;
        bit          chk;
        int          sel;
        logic [31:0] expected;
        string       name;
    } vec_t;

    logic clk;
    logic clr;
    int   checks;
    int   errors;
    vec_t prog[$];

    datapath_if dif ();

    datapath dut (
        .clk (clk),
        .clr (clr),
        .dp  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int pos);
        logic [31:0] v;
        v = 32'd0;
        v[pos] = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] c, input logic [31:0] md);
        dif.MDatain   = md;
        dif.PCout     = c[S_PCOUT];
        dif.Zlowout   = c[S_ZLOWOUT];
        dif.Zhighout  = c[S_ZHIGHOUT];
        dif.MDRout    = c[S_MDROUT];
        dif.R2out     = c[S_R2OUT];
        dif.R3out     = c[S_R3OUT];
        dif.R7out     = c[S_R7OUT];
        dif.LOout     = c[S_LOOUT];
        dif.HIout     = c[S_HIOUT];
        dif.InPortout = c[S_INOUT];
        dif.Cout      = c[S_COUT];
        dif.PCin      = c[S_PCIN];
        dif.IRin      = c[S_IRIN];
        dif.MARin     = c[S_MARIN];
        dif.MDRin     = c[S_MDRIN];
        dif.Yin       = c[S_YIN];
        dif.Zin       = c[S_ZIN];
        dif.R6in      = c[S_R6IN];
        dif.R7in      = c[S_R7IN];
        dif.IncPC     = c[S_INCPC];
        dif.AND       = c[S_AND];
        dif.OR        = c[S_OR];
        dif.NEG       = c[S_NEG];
        dif.NOT       = c[S_NOT];
        dif.Read      = c[S_READ];
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_R6:  return dut.r6;
            SEL_MAR: return dut.mar;
            SEL_IR:  return dut.ir;
            default: return dif.BusMuxOut;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [31:0] c, input logic [31:0] md, input bit chk,
                          input int sel, input logic [31:0] e, input string name);
        vec_t v;
        v.ctl      = c;
        v.mdata    = md;
        v.chk      = chk;
        v.sel      = sel;
        v.expected = e;
        v.name     = name;
        prog.push_back(v);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Whole microprogram, assuming all registers are zero when it starts.
    task automatic buildProgram();
        // operand loads
        addVec(b(S_READ) | b(S_MDRIN), 32'h12, 1, SEL_BUS, 32'h0, "idle_bus_zero");
        addVec(b(S_MDROUT) | b(S_R7IN), 32'h0, 1, SEL_BUS, 32'h12, "mdr_to_r7");
        addVec(b(S_READ) | b(S_MDRIN), 32'h18, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_MDROUT) | b(S_R6IN), 32'h0, 1, SEL_BUS, 32'h18, "mdr_to_r6");
        addVec(b(S_R7OUT), 32'h0, 1, SEL_BUS, 32'h12, "r7_hold");
        addVec(32'h0, 32'h0, 1, SEL_R6, 32'h18, "r6_load");
        // fetch
        addVec(b(S_PCOUT) | b(S_MARIN) | b(S_INCPC) | b(S_ZIN), 32'h0, 1, SEL_BUS, 32'h0, "fetch_t0");
        addVec(b(S_ZLOWOUT) | b(S_PCIN) | b(S_READ) | b(S_MDRIN), 32'h28918000, 1, SEL_BUS, 32'h1, "fetch_t1");
        addVec(b(S_MDROUT) | b(S_IRIN), 32'h0, 1, SEL_BUS, 32'h28918000, "fetch_t2");
        addVec(32'h0, 32'h0, 1, SEL_IR, 32'h28918000, "ir_after_fetch");
        addVec(32'h0, 32'h0, 1, SEL_MAR, 32'h0, "mar_after_fetch");
        addVec(b(S_PCOUT), 32'h0, 1, SEL_BUS, 32'h1, "pc_after_fetch");
        addVec(b(S_COUT), 32'h0, 1, SEL_BUS, 32'h00018000, "c_positive");
        addVec(b(S_R7OUT) | b(S_MARIN), 32'h0, 1, SEL_BUS, 32'h12, "r7_to_mar");
        addVec(32'h0, 32'h0, 1, SEL_MAR, 32'h12, "mar_load");
        // NOT
        addVec(b(S_R7OUT) | b(S_NOT) | b(S_ZIN), 32'h0, 1, SEL_BUS, 32'h12, "not_src");
        addVec(b(S_ZLOWOUT) | b(S_R6IN), 32'h0, 1, SEL_BUS, 32'hFFFFFFED, "not_zlow");
        addVec(b(S_ZHIGHOUT), 32'h0, 1, SEL_BUS, 32'h0, "not_zhigh");
        addVec(32'h0, 32'h0, 1, SEL_R6, 32'hFFFFFFED, "r6_from_z");
        // AND / OR / NEG with Y = 0x12, R7 = 0x18
        addVec(b(S_R7OUT) | b(S_YIN), 32'h0, 1, SEL_BUS, 32'h12, "r7_to_y");
        addVec(b(S_READ) | b(S_MDRIN), 32'h18, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_MDROUT) | b(S_R7IN), 32'h0, 1, SEL_BUS, 32'h18, "mdr_to_r7_b");
        addVec(b(S_R7OUT) | b(S_AND) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h10, "alu_and");
        addVec(b(S_R7OUT) | b(S_OR) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h1A, "alu_or");
        addVec(b(S_R7OUT) | b(S_NEG) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'hFFFFFFE8, "alu_neg");
        addVec(b(S_R7OUT) | b(S_AND) | b(S_OR) | b(S_NEG) | b(S_NOT) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h10, "alu_prio_and");
        addVec(b(S_R7OUT) | b(S_OR) | b(S_NEG) | b(S_NOT) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h1A, "alu_prio_or");
        addVec(b(S_R7OUT) | b(S_NEG) | b(S_NOT) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'hFFFFFFE8, "alu_prio_neg");
        addVec(b(S_R7OUT) | b(S_INCPC) | b(S_AND) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h19, "alu_prio_inc");
        addVec(b(S_R7OUT) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h0, "alu_none");
        addVec(b(S_ZHIGHOUT), 32'h0, 1, SEL_BUS, 32'h0, "alu_none_zhigh");
        // bus priority (PC = 1, MDR = 0x18, R7 = 0x18, C = 0x18000)
        addVec(b(S_PCOUT) | b(S_MDROUT), 32'h0, 1, SEL_BUS, 32'h1, "prio_pc_mdr");
        addVec(b(S_MDROUT) | b(S_R2OUT), 32'h0, 1, SEL_BUS, 32'h18, "prio_mdr_r2");
        addVec(b(S_R7OUT) | b(S_COUT), 32'h0, 1, SEL_BUS, 32'h18, "prio_r7_c");
        addVec(b(S_LOOUT) | b(S_COUT), 32'h0, 1, SEL_BUS, 32'h0, "prio_lo_c");
        // read-modify-write, MDR from bus, multi-load
        addVec(b(S_R7OUT) | b(S_R7IN), 32'h0, 1, SEL_BUS, 32'h18, "r7_rmw_src");
        addVec(b(S_R7OUT), 32'h0, 1, SEL_BUS, 32'h18, "r7_rmw");
        addVec(b(S_R7OUT) | b(S_MDRIN), 32'h55, 1, SEL_BUS, 32'h18, "mdr_bus_src");
        addVec(b(S_MDROUT), 32'h0, 1, SEL_BUS, 32'h18, "mdr_from_bus");
        addVec(b(S_PCOUT) | b(S_YIN) | b(S_R6IN) | b(S_MARIN), 32'h0, 1, SEL_BUS, 32'h1, "multi_src");
        addVec(32'h0, 32'h0, 1, SEL_R6, 32'h1, "multi_r6");
        addVec(32'h0, 32'h0, 1, SEL_MAR, 32'h1, "multi_mar");
        addVec(b(S_R7OUT) | b(S_OR) | b(S_ZIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h19, "multi_y");
        // C sign extension and PC increment wrap
        addVec(b(S_READ) | b(S_MDRIN), 32'h0007FFFF, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_MDROUT) | b(S_IRIN), 32'h0, 1, SEL_BUS, 32'h0007FFFF, "ir_load_c");
        addVec(b(S_COUT), 32'h0, 1, SEL_BUS, 32'hFFFFFFFF, "c_all_ones");
        addVec(b(S_COUT) | b(S_PCIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_PCOUT) | b(S_INCPC) | b(S_ZIN), 32'h0, 1, SEL_BUS, 32'hFFFFFFFF, "pc_max");
        addVec(b(S_ZLOWOUT), 32'h0, 1, SEL_BUS, 32'h0, "inc_wrap");
        addVec(b(S_ZHIGHOUT), 32'h0, 1, SEL_BUS, 32'h0, "inc_wrap_zhigh");
        addVec(b(S_READ) | b(S_MDRIN), 32'hFFF3FFFF, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_MDROUT) | b(S_IRIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_COUT), 32'h0, 1, SEL_BUS, 32'h0003FFFF, "c_upper_ignored");
        addVec(b(S_READ) | b(S_MDRIN), 32'h00040000, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_MDROUT) | b(S_IRIN), 32'h0, 0, SEL_BUS, 32'h0, "");
        addVec(b(S_COUT), 32'h0, 1, SEL_BUS, 32'hFFFC0000, "c_sign_boundary");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        applyStimulus(b(S_PCOUT), 32'h0);
        #2;
        checkOutput("rst_initial_pc", dif.BusMuxOut, 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        nextCycle();

        // R7 = 0x12, then an asynchronous clear must zero it mid-cycle
        applyStimulus(b(S_READ) | b(S_MDRIN), 32'h12);
        nextCycle();
        applyStimulus(b(S_MDROUT) | b(S_R7IN), 32'h0);
        nextCycle();
        applyStimulus(b(S_R7OUT), 32'h0);
        #2;
        checkOutput("r7_preload", dif.BusMuxOut, 32'h12);
        #1;
        clr = 1'b1;
        #1;
        checkOutput("r7_async_clr", dif.BusMuxOut, 32'h0);
        applyStimulus(b(S_READ) | b(S_MDRIN) | b(S_R7IN) | b(S_PCIN), 32'h55);
        nextCycle();
        applyStimulus(b(S_MDROUT), 32'h0);
        #1;
        checkOutput("mdr_load_ignored", dif.BusMuxOut, 32'h0);
        applyStimulus(b(S_PCOUT), 32'h0);
        #1;
        checkOutput("pc_load_ignored", dif.BusMuxOut, 32'h0);
        #1;
        clr = 1'b0;
        nextCycle();

        for (int i = S_PCOUT; i <= S_COUT; i++) begin
            applyStimulus(b(i), 32'h0);
            #2;
            checkOutput($sformatf("rst_src_%0d", i), dif.BusMuxOut, 32'h0);
            nextCycle();
        end

        buildProgram();
        for (int i = 0; i < prog.size(); i++) begin
            applyStimulus(prog[i].ctl, prog[i].mdata);
            #2;
            if (prog[i].chk)
                checkOutput(prog[i].name, observe(prog[i].sel), prog[i].expected);
            nextCycle();
        end

        // clr pulsed and released inside a fetch T0 cycle; the edge then loads normally
        applyStimulus(b(S_PCOUT) | b(S_MARIN) | b(S_INCPC) | b(S_ZIN), 32'h0);
        #1;
        clr = 1'b1;
        #1;
        checkOutput("clr_mid_bus", dif.BusMuxOut, 32'h0);
        #1;
        clr = 1'b0;
        nextCycle();
        applyStimulus(b(S_ZLOWOUT), 32'h0);
        #2;
        checkOutput("post_release_z", dif.BusMuxOut, 32'h1);
        checkOutput("post_release_mar", observe(SEL_MAR), 32'h0);
        nextCycle();
        applyStimulus(32'h0, 32'h0);
        #2;
        checkOutput("final_idle_bus", dif.BusMuxOut, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit CPU datapath: register subset, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, C-constant and in-port sources on one shared bus, plus a small logic/increment ALU. Driven cycle by cycle by an external control unit (or testbench FSM) through one-hot load/drive strobes. It is the execution core under the control unit and fetches/decodes nothing itself.

## Interface
Parameters: none.
- clk  in  1  system clock; all registers load on rising edge
- clr  in  1  asynchronous, active-high reset
- MDatain  in  32  memory read data
- Read  in  1  MDR input mux select: 1 = MDatain, 0 = bus
- PCout, Zlowout, Zhighout, MDRout, R2out, R3out, R7out, LOout, HIout, InPortout, Cout  in  1 each  bus drive strobes
- PCin, IRin, MARin, MDRin, Yin, Zin, R6in, R7in  in  1 each  register load enables
- IncPC, AND, OR, NEG, NOT  in  1 each  ALU operation selects
- BusMuxOut  out  32  current bus value, for observation

## Operation
- Internal 32-bit registers: PC, IR, MAR, MDR, Y, HI, LO, InPort, R2, R3, R6, R7. Z is 64-bit (Zlow = Z[31:0], Zhigh = Z[63:32]).
- Bus, combinational, priority when more than one strobe is high: PCout > Zlowout > Zhighout > MDRout > R2out > R3out > R7out > LOout > HIout > InPortout > Cout. No strobe high: bus = 0.
- C source: IR[18:0] sign-extended to 32 bits.
- Loads on rising clk when the enable is high: PC, IR, MAR, Y, R6, R7 take the bus value. MDR takes Read ? MDatain : bus. Z takes the ALU result when Zin is high.
- HI, LO, InPort, R2, R3 have no load path. They stay 0 after reset and are readable on the bus.
- ALU operand A = Y, operand B = bus. Select priority: IncPC > AND > OR > NEG > NOT.
  - IncPC: Zlow = B + 1, modulo 2^32.
  - AND: Zlow = A & B.
  - OR: Zlow = A | B.
  - NEG: Zlow = (~B) + 1, two's complement, modulo 2^32.
  - NOT: Zlow = ~B.
  - No select: Zlow = 0.
  - Zhigh = 0 for every operation.
- Enables are independent. Several loads in one cycle all capture the same pre-edge bus value.

## Timing
- clr high (asynchronous): every internal register, including Z, goes to 0 immediately and stays 0 while clr is high. Loads are ignored during reset. BusMuxOut reflects the zeroed sources.
- BusMuxOut and the ALU result are combinational from the strobes and register contents in the same cycle.
- Register load latency is 1 edge: a value driven in cycle n is readable in cycle n+1.
- Read-modify-write of one register in one cycle is legal. Example: R7out and R7in both high with no ALU involvement reloads R7 with its own value.
- Zin with an ALU select: Z captures the result at the edge ending that cycle, and Zlowout can drive it the next cycle.
- Standard fetch, 3 cycles:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Deasserting clr mid-sequence does not alter the strobes. The first edge after release loads normally.

## Test plan
- Reset: load R7 = 0x12, pulse clr -> all registers read 0 via bus; BusMuxOut = 0 with no strobes.
- Operand load: MDatain = 0x12, Read+MDRin one edge, then MDRout+R7in -> R7 = 0x12. Repeat with 0x18 into R6 -> R6 = 0x18.
- Fetch: PC = 0, run T0–T2 with MDatain = 0x28918000 -> MAR = 0, PC = 1, IR = 0x28918000.
- NOT: R7 = 0x12, R7out+NOT+Zin, then Zlowout+R6in -> R6 = 0xFFFFFFED, Zhigh = 0.
- AND/OR/NEG: Y = 0x12 (R7out+Yin), R7 = 0x18 -> AND gives 0x10, OR gives 0x1A, NEG of 0x18 gives 0xFFFFFFE8. IncPC with PC = 0xFFFFFFFF gives 0.
- Bus priority and C: PCout and MDRout high together -> bus = PC. IR = 0x0007FFFF, Cout -> bus = 0xFFFFFFFF.
